// File: rtl/phase_extractor_pkg.sv
// -----------------------------------------------------------------------------
// phase_extractor_pkg
// Shared types and constants for the CORDIC phase extractor.
//   state_t     : controller states (IDLE -> ROTATE -> FINISH -> IDLE)
//   ATAN_TABLE  : round(atan(2^-i)/pi * 2^31), i = 0..31 (binary angle, 2^31 = pi)
//   atan_lsb()  : table entry rescaled to a PHASE_BITS binary angle with rounding
// -----------------------------------------------------------------------------
package phase_extractor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ROTATE,
        FINISH
    } state_t;

    localparam logic [31:0] ATAN_TABLE [32] = '{
        32'd536870912, 32'd316933406, 32'd167458907, 32'd85004756,
        32'd42667331,  32'd21354465,  32'd10679838,  32'd5340245,
        32'd2670163,   32'd1335087,   32'd667544,    32'd333772,
        32'd166886,    32'd83443,     32'd41722,     32'd20861,
        32'd10430,     32'd5215,      32'd2608,      32'd1304,
        32'd652,       32'd326,       32'd163,       32'd81,
        32'd41,        32'd20,        32'd10,        32'd5,
        32'd3,         32'd1,         32'd1,         32'd0
    };

    // All entries are non-negative, so a logical shift equals the arithmetic one.
    function automatic logic [31:0] atan_lsb(input logic [4:0] i,
                                             input int unsigned phase_bits);
        int unsigned sh;
        logic [31:0] e;
        sh = 32 - phase_bits;
        e  = ATAN_TABLE[i];
        if (sh == 0) begin
            return e;
        end
        return (e + (32'd1 << (sh - 1))) >> sh;
    endfunction

endpackage

// File: rtl/phase_unwrapper.sv
// -----------------------------------------------------------------------------
// phase_unwrapper
// Multi-turn phase accumulator. On each enable the signed wrapped difference
// between the new and previous phase is added to the accumulator.
//   clk_i, reset_ni : clock, asynchronous active-low reset
//   en_i            : one-cycle strobe, phase_new_i is a fresh result
//   clear_i         : re-seed accumulator with the current (or new) phase
//   phase_new_i     : freshly computed wrapped phase
//   phase_o         : registered wrapped phase (doubles as previous phase)
//   unwrapped_o     : unwrapped phase, PHASE_BITS+TURN_BITS wide, wrapping
// -----------------------------------------------------------------------------
module phase_unwrapper #(
    parameter int unsigned PHASE_BITS = 24,
    parameter int unsigned TURN_BITS  = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_ni,
    input  logic                                   en_i,
    input  logic                                   clear_i,
    input  logic signed [PHASE_BITS-1:0]           phase_new_i,
    output logic signed [PHASE_BITS-1:0]           phase_o,
    output logic signed [PHASE_BITS+TURN_BITS-1:0] unwrapped_o
);

    localparam int unsigned UW = PHASE_BITS + TURN_BITS;

    logic signed [PHASE_BITS-1:0] prev_q, prev_d;
    logic signed [UW-1:0]         acc_q, acc_d;
    logic signed [PHASE_BITS-1:0] delta;

    // Modular subtraction read as signed gives the shortest step in [-pi, pi).
    assign delta = phase_new_i - prev_q;

    always_comb begin
        prev_d = prev_q;
        acc_d  = acc_q;
        if (en_i) begin
            prev_d = phase_new_i;
            acc_d  = acc_q + UW'(delta);
        end
        if (clear_i) begin
            acc_d = en_i ? UW'(phase_new_i) : UW'(prev_q);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            prev_q <= '0;
            acc_q  <= '0;
        end else begin
            prev_q <= prev_d;
            acc_q  <= acc_d;
        end
    end

    assign phase_o     = prev_q;
    assign unwrapped_o = acc_q;

endmodule

// File: rtl/cordic_phase_extractor.sv
// -----------------------------------------------------------------------------
// cordic_phase_extractor
// Iterative vectoring CORDIC computing atan2(sin, cos), one micro-rotation per
// clock, followed by a multi-turn unwrapper.
//   clk_i, reset_ni  : clock, asynchronous active-low reset
//   tick_i           : sin_i/cos_i valid strobe
//   sin_i, cos_i     : signed quadrature / in-phase samples
//   unwrap_clear_i   : re-seed unwrapped accumulator
//   phase_o          : wrapped phase, binary angle, [-pi, pi)
//   unwrapped_o      : unwrapped phase
//   done_o           : one-cycle pulse, outputs updated
//   busy_o           : high while not IDLE
//   missed_o         : sticky, a tick arrived while busy
// -----------------------------------------------------------------------------
module cordic_phase_extractor
    import phase_extractor_pkg::*;
#(
    parameter int unsigned NUM_BITS   = 24,
    parameter int unsigned PHASE_BITS = 24,
    parameter int unsigned NUM_ITER   = 20,
    parameter int unsigned TURN_BITS  = 8
) (
    input  logic                                   clk_i,
    input  logic                                   reset_ni,
    input  logic                                   tick_i,
    input  logic signed [NUM_BITS-1:0]             sin_i,
    input  logic signed [NUM_BITS-1:0]             cos_i,
    input  logic                                   unwrap_clear_i,
    output logic signed [PHASE_BITS-1:0]           phase_o,
    output logic signed [PHASE_BITS+TURN_BITS-1:0] unwrapped_o,
    output logic                                   done_o,
    output logic                                   busy_o,
    output logic                                   missed_o
);

    // Two guard bits: CORDIC gain (~1.647 * sqrt 2) and negating the most-negative input.
    localparam int unsigned     XW      = NUM_BITS + 2;
    localparam logic [4:0]      LAST    = 5'(NUM_ITER - 1);
    localparam logic [PHASE_BITS-1:0] QUARTER = PHASE_BITS'(1) << (PHASE_BITS - 2);

    state_t                 state_q, state_d;
    logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
    logic [PHASE_BITS-1:0]  z_q, z_d;
    logic [4:0]             iter_q, iter_d;
    logic                   zero_q, zero_d;
    logic                   done_q, done_d;
    logic                   missed_q, missed_d;

    logic signed [XW-1:0]   sin_x, cos_x;
    logic [PHASE_BITS-1:0]  atan_i;
    logic                   finish;
    logic signed [PHASE_BITS-1:0] phase_new;

    assign sin_x  = XW'(sin_i);
    assign cos_x  = XW'(cos_i);
    assign atan_i = PHASE_BITS'(atan_lsb(iter_q, PHASE_BITS));
    assign finish = (state_q == FINISH);
    assign phase_new = zero_q ? '0 : z_q;

    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        z_d      = z_q;
        iter_d   = iter_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        missed_d = missed_q;

        unique case (state_q)
            IDLE: begin
                if (tick_i) begin
                    state_d = ROTATE;
                    iter_d  = '0;
                    zero_d  = (sin_i == '0) && (cos_i == '0);
                    // Fold left half-plane into the right half-plane by +-90 degrees.
                    if (!cos_i[NUM_BITS-1]) begin
                        x_d = cos_x;
                        y_d = sin_x;
                        z_d = '0;
                    end else if (!sin_i[NUM_BITS-1]) begin
                        x_d = sin_x;
                        y_d = -cos_x;
                        z_d = QUARTER;
                    end else begin
                        x_d = -sin_x;
                        y_d = cos_x;
                        z_d = -QUARTER;
                    end
                end
            end
            ROTATE: begin
                if (!y_q[XW-1]) begin
                    x_d = x_q + (y_q >>> iter_q);
                    y_d = y_q - (x_q >>> iter_q);
                    z_d = z_q + atan_i;
                end else begin
                    x_d = x_q - (y_q >>> iter_q);
                    y_d = y_q + (x_q >>> iter_q);
                    z_d = z_q - atan_i;
                end
                iter_d = iter_q + 5'd1;
                if (iter_q == LAST) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (tick_i && (state_q != IDLE)) begin
            missed_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= IDLE;
            x_q      <= '0;
            y_q      <= '0;
            z_q      <= '0;
            iter_q   <= '0;
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            missed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            z_q      <= z_d;
            iter_q   <= iter_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            missed_q <= missed_d;
        end
    end

    phase_unwrapper #(
        .PHASE_BITS (PHASE_BITS),
        .TURN_BITS  (TURN_BITS)
    ) u_unwrapper (
        .clk_i       (clk_i),
        .reset_ni    (reset_ni),
        .en_i        (finish),
        .clear_i     (unwrap_clear_i),
        .phase_new_i (phase_new),
        .phase_o     (phase_o),
        .unwrapped_o (unwrapped_o)
    );

    assign done_o   = done_q;
    assign busy_o   = (state_q != IDLE);
    assign missed_o = missed_q;

endmodule
